// File: rtl/clkburst_pkg.sv
// Shared definitions for the clock-burst gate controller.
package clkburst_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/clkburst.sv
// Clock-burst controller: drives the gate of a downstream glitch-free clock gate
// so exactly len clk pulses pass per accepted request.
module clkburst
    import clkburst_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter bit          SEAMLESS = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] len,
    input  logic         abort,
    output logic         ready,
    output logic         gate,
    output logic         busy,
    output logic [W-1:0] remaining,
    output logic         done
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_cnt;
    logic [W-1:0]   w_cnt_nxt;
    logic           r_gate;
    logic           w_gate_nxt;
    logic           r_busy;
    logic           w_busy_nxt;
    logic           r_done;
    logic           w_done_nxt;
    logic           r_done_pend;
    logic           w_done_pend_nxt;
    logic           w_last;
    logic           w_ready;
    logic           w_accept;
    logic           w_len_zero;

    assign w_last     = (r_cnt == '0);
    assign w_ready    = (r_state == ST_IDLE) || (SEAMLESS && (r_state == ST_RUN) && w_last);
    assign w_accept   = start & w_ready & ~abort;
    assign w_len_zero = (len == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_gate      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_done_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gate      <= w_gate_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_done_pend <= w_done_pend_nxt;
        end
    end

    // A zero-length request taken on the last RUN cycle owes its done strobe one
    // cycle after the finishing burst's strobe; r_done_pend carries it.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_gate_nxt      = r_gate;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done_pend;
        w_done_pend_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_len_zero) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = len - 1'b1;
                        w_gate_nxt  = 1'b1;
                        w_busy_nxt  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_gate_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (w_last) begin
                    w_done_nxt = 1'b1;
                    if (w_accept && !w_len_zero) begin
                        w_cnt_nxt = len - 1'b1;
                    end else begin
                        w_state_nxt     = ST_IDLE;
                        w_gate_nxt      = 1'b0;
                        w_busy_nxt      = 1'b0;
                        w_done_pend_nxt = w_accept;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
        endcase
    end

    assign ready     = w_ready;
    assign gate      = r_gate;
    assign busy      = r_busy;
    assign remaining = r_cnt;
    assign done      = r_done;

endmodule

// File: tb/tb_clkburst.sv
// Scoreboard bench: two controllers (W=8 seamless, W=4 gapped) behind latch-based
// clock gates, checked per cycle against a burst-timeline model and by gated pulse counts.
module tb_clkburst;

    typedef struct {
        int n;
        int v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] len = '0;
    logic [3:0] len4;

    logic       rdy0, g0, b0, d0;
    logic [7:0] rem0;
    logic       rdy1, g1, b1, d1;
    logic [3:0] rem1;

    logic en0 = 1'b0, en1 = 1'b0;
    logic gclk0, gclk1;

    int n_checks = 0;
    int n_err    = 0;
    int edge_cnt = 0;
    int act_p0 = 0, act_p1 = 0;
    int exp_p0 = 0, exp_p1 = 0;
    int base0 = 0, base1 = 0;

    exp_t q0[$];
    exp_t q1[$];

    bit m_active [2];
    int m_last   [2];
    bit m_done   [2][512];

    assign len4 = len[3:0];

    clkburst #(.W(8), .SEAMLESS(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .ready(rdy0), .gate(g0), .busy(b0), .remaining(rem0), .done(d0)
    );

    clkburst #(.W(4), .SEAMLESS(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .len(len4), .abort(abort),
        .ready(rdy1), .gate(g1), .busy(b1), .remaining(rem1), .done(d1)
    );

    // Downstream glitch-free gates: enable captured while clk is low.
    always_latch if (!clk) en0 = g0;
    always_latch if (!clk) en1 = g1;
    assign gclk0 = clk & en0;
    assign gclk1 = clk & en1;

    initial forever #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;
    always @(posedge gclk0) if (!rst) act_p0++;
    always @(posedge gclk1) if (!rst) act_p1++;

    function automatic int pack(logic g, logic b, logic d, logic r, logic [7:0] rem);
        return {20'd0, g, b, d, r, rem};
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Each accepted burst of L occupies edges n..n+L-1 with gate high and owes a
    // done after edge n+L; abort cancels that debt.
    task automatic model_step(input int i, input bit s, input int L, input bit a,
                              input int n, output int v);
        bit running, rdy, g, d, seam;
        int rem;
        seam    = (i == 0);
        running = m_active[i] && (n - 1 <= m_last[i]);
        if (!running) m_active[i] = 1'b0;
        rdy = !running || (seam && m_last[i] == n - 1);
        if (a) begin
            if (running) begin
                m_done[i][(m_last[i] + 1) % 512] = 1'b0;
                m_active[i] = 1'b0;
            end
        end else if (s && rdy) begin
            if (L != 0) begin
                m_active[i] = 1'b1;
                m_last[i]   = n + L - 1;
                m_done[i][(n + L) % 512] = 1'b1;
            end else begin
                m_done[i][(running ? n + 1 : n) % 512] = 1'b1;
            end
        end
        g   = m_active[i] && (n <= m_last[i]);
        rem = g ? m_last[i] - n : 0;
        d   = m_done[i][n % 512];
        m_done[i][n % 512] = 1'b0;
        v = pack(g, g, d, !g || (seam && rem == 0), 8'(rem));
    endtask

    task automatic step(input bit s, input int L, input bit a);
        exp_t e;
        int   n, v;
        start = s;
        len   = L[7:0];
        abort = a;
        n = edge_cnt + 1;
        model_step(0, s, L & 255, a, n, v);
        e.n = n; e.v = v; q0.push_back(e);
        model_step(1, s, L & 15, a, n, v);
        e.n = n; e.v = v; q1.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 0, 1'b0);
    endtask

    task automatic mark();
        base0 = act_p0;
        base1 = act_p1;
    endtask

    task automatic chk_pulses(input string name, input int d0x, input int d1x);
        check({name, " pulses inst0"}, act_p0 - base0, d0x);
        check({name, " pulses inst1"}, act_p1 - base1, d1x);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1; start = 1'b0; abort = 1'b0; len = '0;
        q0.delete(); q1.delete();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_last[i]   = 0;
            for (int j = 0; j < 512; j++) m_done[i][j] = 1'b0;
        end
        #1;
        check("reset immediate inst0", pack(g0, b0, d0, rdy0, rem0), pack(0, 0, 0, 1, 0));
        check("reset immediate inst1", pack(g1, b1, d1, rdy1, {4'd0, rem1}), pack(0, 0, 0, 1, 0));
        repeat (2) @(posedge clk);
        #1;
        check("reset held inst0", pack(g0, b0, d0, rdy0, rem0), pack(0, 0, 0, 1, 0));
        check("reset held inst1", pack(g1, b1, d1, rdy1, {4'd0, rem1}), pack(0, 0, 0, 1, 0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin : monitor
        exp_t e;
        bit   p0, p1;
        p0 = 1'b0;
        p1 = 1'b0;
        forever begin
            @(negedge clk);
            while (q0.size() > 0 && q0[0].n < edge_cnt) begin
                check("inst0 missed edge", q0[0].n, edge_cnt);
                void'(q0.pop_front());
            end
            while (q1.size() > 0 && q1[0].n < edge_cnt) begin
                check("inst1 missed edge", q1[0].n, edge_cnt);
                void'(q1.pop_front());
            end
            if (q0.size() > 0 && q0[0].n == edge_cnt) begin
                e = q0.pop_front();
                check($sformatf("inst0 edge %0d", e.n), pack(g0, b0, d0, rdy0, rem0), e.v);
                p0 = e.v[11];
            end
            if (q1.size() > 0 && q1[0].n == edge_cnt) begin
                e = q1.pop_front();
                check($sformatf("inst1 edge %0d", e.n), pack(g1, b1, d1, rdy1, {4'd0, rem1}), e.v);
                p1 = e.v[11];
            end
            @(posedge clk or posedge rst);
            if (rst) begin
                p0 = 1'b0;
                p1 = 1'b0;
            end else begin
                if (p0) exp_p0++;
                if (p1) exp_p1++;
                p0 = 1'b0;
                p1 = 1'b0;
            end
        end
    end

    initial begin : stimulus
        #2;
        do_reset();

        mark(); step(1'b1, 5, 1'b0); idle(8); chk_pulses("len5", 5, 5);
        mark(); step(1'b1, 0, 1'b0); idle(3); chk_pulses("len0", 0, 0);

        mark(); step(1'b1, 3, 1'b0); idle(2); step(1'b1, 2, 1'b0); idle(6);
        chk_pulses("seamless", 5, 3);

        mark(); step(1'b1, 2, 1'b0); idle(1); step(1'b1, 0, 1'b0); idle(4);
        chk_pulses("seamless len0", 2, 2);

        mark(); step(1'b1, 10, 1'b0); idle(2); step(1'b0, 0, 1'b1); idle(3);
        chk_pulses("abort", 3, 3);

        mark(); step(1'b1, 4, 1'b1); idle(3); chk_pulses("abort idle", 0, 0);

        mark(); step(1'b1, 8, 1'b0); idle(3); do_reset();
        chk_pulses("reset midburst", 3, 3);
        mark(); step(1'b1, 1, 1'b0); idle(3); chk_pulses("after reset", 1, 1);

        mark(); step(1'b1, 15, 1'b0); idle(18); chk_pulses("len15", 15, 15);
        mark(); step(1'b1, 255, 1'b0); idle(258); chk_pulses("len255", 255, 15);

        for (int k = 0; k < 1500; k++) begin
            step(($urandom % 3) == 0, int'($urandom_range(0, 12)), ($urandom % 16) == 0);
        end
        idle(16);

        repeat (2) @(negedge clk);
        #1;
        check("pulse total inst0", act_p0, exp_p0);
        check("pulse total inst1", act_p1, exp_p1);
        check("scoreboard drained", q0.size() + q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
